// File: rtl/hazard_ctrl_pkg.sv
// Shared forwarding select codes and multiply/divide latency defaults for the
// hazard controller and the datapath forwarding muxes.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_D_ORIG = 2'd0;
   localparam logic [1:0] FWD_D_E    = 2'd1;
   localparam logic [1:0] FWD_D_M    = 2'd2;

   localparam logic [1:0] FWD_E_ORIG = 2'd0;
   localparam logic [1:0] FWD_E_M    = 2'd1;
   localparam logic [1:0] FWD_E_W    = 2'd2;

   localparam logic       FWD_M_ORIG = 1'b0;
   localparam logic       FWD_M_W    = 1'b1;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Wide enough to hold the longer of the two latencies, never narrower than 1 bit.
   function automatic int mdCntWidth(input int multCycles, input int divCycles);
      int longest;
      longest = (divCycles > multCycles) ? divCycles : multCycles;
      return (longest < 1) ? 1 : $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs and forwarding/stall outputs; the pipeline
// control drives it as master and hazard_ctrl consumes it as slave.
interface hazard_ctrl_if #(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5,
   parameter int T_W     = 3
);
   logic [NUM_SRC*T_W-1:0]    tuse_d;
   logic [NUM_SRC*REG_AW-1:0] rs_d;
   logic [NUM_SRC*REG_AW-1:0] rs_e;
   logic [NUM_SRC*REG_AW-1:0] rs_m;
   logic [REG_AW-1:0]         rd_e;
   logic [REG_AW-1:0]         rd_m;
   logic [REG_AW-1:0]         rd_w;
   logic [T_W-1:0]            tnew_e;
   logic [T_W-1:0]            tnew_m;
   logic [T_W-1:0]            tnew_w;
   logic                      md_start_e;
   logic                      md_is_div_e;
   logic                      md_use_d;
   logic [2*NUM_SRC-1:0]      fwd_d;
   logic [2*NUM_SRC-1:0]      fwd_e;
   logic [NUM_SRC-1:0]        fwd_m;
   logic                      stall;
   logic                      md_busy;
   logic [31:0]               stall_cnt;

   modport master (
      output tuse_d, rs_d, rs_e, rs_m, rd_e, rd_m, rd_w,
             tnew_e, tnew_m, tnew_w, md_start_e, md_is_div_e, md_use_d,
      input  fwd_d, fwd_e, fwd_m, stall, md_busy, stall_cnt
   );

   modport slave (
      input  tuse_d, rs_d, rs_e, rs_m, rd_e, rd_m, rd_w,
             tnew_e, tnew_m, tnew_w, md_start_e, md_is_div_e, md_use_d,
      output fwd_d, fwd_e, fwd_m, stall, md_busy, stall_cnt
   );

endinterface

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// Multiply/divide occupancy tracker: a down-counter loaded on an MD start and
// a registered busy flag that is high while the count is nonzero.
module md_busy_tracker
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_isDiv,
   output logic o_busy
);
   localparam int CW = mdCntWidth(MULT_CYCLES, DIV_CYCLES);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cntNext;
   logic          r_busy;

   // A start that arrives while the unit is still counting is ignored.
   always_comb begin
      w_cntNext = r_cnt;
      if (i_start && (r_cnt == '0)) begin
         w_cntNext = i_isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (r_cnt != '0) begin
         w_cntNext = r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else begin
         r_cnt  <= w_cntNext;
         r_busy <= (w_cntNext != '0);
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: per-source forwarding selects at D/E/M
// and the D-stage stall. Optional stall counter enabled by HAZARD_STALL_CNT_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int REG_AW      = 5,
   parameter int T_W         = 3,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  bus
);
   logic               w_eReady;
   logic               w_mReady;
   logic               w_wReady;
   logic               w_eWrites;
   logic               w_mWrites;
   logic               w_wWrites;
   logic [NUM_SRC-1:0] w_stallSrc;
   logic               w_mdBusy;
   logic               w_mdStall;
   logic               w_stall;

   assign w_eReady  = (bus.tnew_e == '0);
   assign w_mReady  = (bus.tnew_m == '0);
   assign w_wReady  = (bus.tnew_w == '0);
   assign w_eWrites = (bus.rd_e != '0);
   assign w_mWrites = (bus.rd_m != '0);
   assign w_wWrites = (bus.rd_w != '0);

   // The youngest matching producer owns the source; if it is not ready the
   // select stays at orig even when an older ready producer also matches.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_AW-1:0] w_rsD;
      logic [REG_AW-1:0] w_rsE;
      logic [REG_AW-1:0] w_rsM;
      logic [T_W-1:0]    w_tuse;
      logic              w_dMatchE;
      logic              w_dMatchM;
      logic              w_eMatchM;
      logic              w_eMatchW;
      logic              w_mMatchW;

      assign w_rsD  = bus.rs_d[i*REG_AW +: REG_AW];
      assign w_rsE  = bus.rs_e[i*REG_AW +: REG_AW];
      assign w_rsM  = bus.rs_m[i*REG_AW +: REG_AW];
      assign w_tuse = bus.tuse_d[i*T_W +: T_W];

      assign w_dMatchE = w_eWrites && (bus.rd_e == w_rsD);
      assign w_dMatchM = w_mWrites && (bus.rd_m == w_rsD);
      assign w_eMatchM = w_mWrites && (bus.rd_m == w_rsE);
      assign w_eMatchW = w_wWrites && (bus.rd_w == w_rsE);
      assign w_mMatchW = w_wWrites && (bus.rd_w == w_rsM);

      assign bus.fwd_d[2*i +: 2] = w_dMatchE ? (w_eReady ? FWD_D_E : FWD_D_ORIG) :
                                   (w_dMatchM && w_mReady) ? FWD_D_M : FWD_D_ORIG;
      assign bus.fwd_e[2*i +: 2] = w_eMatchM ? (w_mReady ? FWD_E_M : FWD_E_ORIG) :
                                   (w_eMatchW && w_wReady) ? FWD_E_W : FWD_E_ORIG;
      assign bus.fwd_m[i]        = (w_mMatchW && w_wReady) ? FWD_M_W : FWD_M_ORIG;

      assign w_stallSrc[i] = (w_dMatchE && (w_tuse < bus.tnew_e)) ||
                             (w_dMatchM && (w_tuse < bus.tnew_m));
   end

   md_busy_tracker #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdTracker (
      .clk     (clk),
      .reset   (reset),
      .i_start (bus.md_start_e),
      .i_isDiv (bus.md_is_div_e),
      .o_busy  (w_mdBusy)
   );

   assign w_mdStall   = bus.md_use_d && (w_mdBusy || bus.md_start_e);
   assign w_stall     = (|w_stallSrc) || w_mdStall;
   assign bus.stall   = w_stall;
   assign bus.md_busy = w_mdBusy;

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] r_stallCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stallCnt <= '0;
      end else if (w_stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
         r_stallCnt <= r_stallCnt + 32'd1;
      end
   end

   assign bus.stall_cnt = r_stallCnt;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven forwarding/stall vectors
// and hand-written multiply/divide busy, reset and stall-counter sequences.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int NUM_SRC = 2;
   localparam int REG_AW  = 5;
   localparam int T_W     = 3;
   localparam int NVEC    = 15;

   typedef struct {
      logic [NUM_SRC*T_W-1:0]    tuse;
      logic [NUM_SRC*REG_AW-1:0] rsD;
      logic [NUM_SRC*REG_AW-1:0] rsE;
      logic [NUM_SRC*REG_AW-1:0] rsM;
      logic [REG_AW-1:0]         rdE;
      logic [REG_AW-1:0]         rdM;
      logic [REG_AW-1:0]         rdW;
      logic [T_W-1:0]            tnE;
      logic [T_W-1:0]            tnM;
      logic [T_W-1:0]            tnW;
      logic [2*NUM_SRC-1:0]      fD;
      logic [2*NUM_SRC-1:0]      fE;
      logic [NUM_SRC-1:0]        fM;
      logic                      st;
   } vec_t;

   typedef struct {
      logic [2*NUM_SRC-1:0] fD;
      logic [2*NUM_SRC-1:0] fE;
      logic [NUM_SRC-1:0]   fM;
      logic                 st;
      logic                 busy;
      logic                 chkBusy;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t sbQ[$];
   vec_t vecs[NVEC];
   vec_t zeroVec;

   hazard_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .T_W(T_W)) hif ();

   hazard_ctrl #(
      .NUM_SRC (NUM_SRC),
      .REG_AW  (REG_AW),
      .T_W     (T_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the test completed");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mkVec(
      input logic [5:0] tuse, input logic [9:0] rsD, input logic [9:0] rsE,
      input logic [9:0] rsM, input logic [4:0] rdE, input logic [4:0] rdM,
      input logic [4:0] rdW, input logic [2:0] tnE, input logic [2:0] tnM,
      input logic [2:0] tnW, input logic [3:0] fD, input logic [3:0] fE,
      input logic [1:0] fM, input logic st);
      vec_t v;
      v.tuse = tuse; v.rsD = rsD; v.rsE = rsE; v.rsM = rsM;
      v.rdE = rdE; v.rdM = rdM; v.rdW = rdW;
      v.tnE = tnE; v.tnM = tnM; v.tnW = tnW;
      v.fD = fD; v.fE = fE; v.fM = fM; v.st = st;
      return v;
   endfunction

   function automatic exp_t expFromVec(input vec_t v);
      exp_t e;
      e.fD = v.fD; e.fE = v.fE; e.fM = v.fM; e.st = v.st;
      e.busy = 1'b0; e.chkBusy = 1'b0;
      return e;
   endfunction

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      hif.tuse_d      = v.tuse;
      hif.rs_d        = v.rsD;
      hif.rs_e        = v.rsE;
      hif.rs_m        = v.rsM;
      hif.rd_e        = v.rdE;
      hif.rd_m        = v.rdM;
      hif.rd_w        = v.rdW;
      hif.tnew_e      = v.tnE;
      hif.tnew_m      = v.tnM;
      hif.tnew_w      = v.tnW;
      hif.md_start_e  = 1'b0;
      hif.md_is_div_e = 1'b0;
      hif.md_use_d    = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard empty actual=none expected=entry", tag);
      end else begin
         e = sbQ.pop_front();
         compareVal({tag, ".fwd_d"}, 32'(hif.fwd_d), 32'(e.fD));
         compareVal({tag, ".fwd_e"}, 32'(hif.fwd_e), 32'(e.fE));
         compareVal({tag, ".fwd_m"}, 32'(hif.fwd_m), 32'(e.fM));
         compareVal({tag, ".stall"}, 32'(hif.stall), 32'(e.st));
         if (e.chkBusy) compareVal({tag, ".md_busy"}, 32'(hif.md_busy), 32'(e.busy));
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(zeroVec);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One MD operation with md_use_d held high; optional illegal second start.
   task automatic runMd(input logic isDiv, input int n, input int extraStartAt,
                        input logic withReset, input string tag);
      int   stallCycles;
      int   busyCycles;
      exp_t e;
      stallCycles = 0;
      busyCycles  = 0;
      if (withReset) doReset();
      for (int c = 0; c <= n + 4; c++) begin
         @(posedge clk);
         #1;
         applyStimulus(zeroVec);
         hif.md_use_d    = 1'b1;
         hif.md_start_e  = (c == 0) || (c == extraStartAt);
         hif.md_is_div_e = (c == 0) ? isDiv : ~isDiv;
         e = expFromVec(zeroVec);
         e.st      = (c <= n);
         e.busy    = (c >= 1) && (c <= n);
         e.chkBusy = 1'b1;
         sbQ.push_back(e);
         @(negedge clk);
         if (hif.stall === 1'b1) stallCycles++;
         if (hif.md_busy === 1'b1) busyCycles++;
         checkOutput($sformatf("%s.c%0d", tag, c));
      end
      compareVal({tag, ".busyCycles"}, 32'(busyCycles), 32'(n));
      compareVal({tag, ".stallCycles"}, 32'(stallCycles), 32'(n + 1));
      applyStimulus(zeroVec);
   endtask

   initial begin
      exp_t e;
      int   expCnt;
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      zeroVec = mkVec('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);

      vecs[0]  = zeroVec;
      vecs[1]  = mkVec(6'o00, {5'd0, 5'd5}, '0, '0, 5'd5, 5'd0, 5'd0, 3'd0, 3'd0, 3'd0, 4'b0001, 4'b0000, 2'b00, 1'b0);
      vecs[2]  = mkVec(6'o00, {5'd0, 5'd5}, '0, '0, 5'd5, 5'd0, 5'd0, 3'd1, 3'd0, 3'd0, 4'b0000, 4'b0000, 2'b00, 1'b1);
      vecs[3]  = mkVec(6'o00, '0, {5'd7, 5'd0}, '0, 5'd7, 5'd7, 5'd7, 3'd0, 3'd0, 3'd0, 4'b0000, 4'b0100, 2'b00, 1'b0);
      vecs[4]  = mkVec(6'o00, '0, {5'd7, 5'd0}, '0, 5'd7, 5'd0, 5'd7, 3'd0, 3'd0, 3'd0, 4'b0000, 4'b1000, 2'b00, 1'b0);
      vecs[5]  = mkVec(6'o00, {5'd9, 5'd0}, '0, '0, 5'd3, 5'd9, 5'd0, 3'd0, 3'd0, 3'd0, 4'b1000, 4'b0000, 2'b00, 1'b0);
      vecs[6]  = mkVec(6'o10, {5'd9, 5'd0}, '0, '0, 5'd9, 5'd9, 5'd0, 3'd2, 3'd0, 3'd0, 4'b0000, 4'b0000, 2'b00, 1'b1);
      vecs[7]  = mkVec(6'o20, {5'd9, 5'd0}, '0, '0, 5'd9, 5'd0, 5'd0, 3'd2, 3'd0, 3'd0, 4'b0000, 4'b0000, 2'b00, 1'b0);
      vecs[8]  = mkVec(6'o00, '0, '0, '0, 5'd0, 5'd0, 5'd0, 3'd3, 3'd3, 3'd0, 4'b0000, 4'b0000, 2'b00, 1'b0);
      vecs[9]  = mkVec(6'o00, '0, '0, {5'd12, 5'd12}, 5'd0, 5'd0, 5'd12, 3'd0, 3'd0, 3'd0, 4'b0000, 4'b0000, 2'b11, 1'b0);
      vecs[10] = mkVec(6'o00, {5'd0, 5'd12}, '0, {5'd0, 5'd12}, 5'd0, 5'd0, 5'd12, 3'd0, 3'd0, 3'd1, 4'b0000, 4'b0000, 2'b00, 1'b0);
      vecs[11] = mkVec(6'o00, {5'd0, 5'd4}, '0, '0, 5'd0, 5'd4, 5'd0, 3'd0, 3'd1, 3'd0, 4'b0000, 4'b0000, 2'b00, 1'b1);
      vecs[12] = mkVec(6'o00, '0, {5'd0, 5'd6}, '0, 5'd0, 5'd6, 5'd6, 3'd0, 3'd1, 3'd0, 4'b0000, 4'b0000, 2'b00, 1'b0);
      vecs[13] = mkVec(6'o00, '0, {5'd0, 5'd6}, '0, 5'd0, 5'd0, 5'd6, 3'd0, 3'd0, 3'd0, 4'b0000, 4'b0010, 2'b00, 1'b0);
      vecs[14] = mkVec(6'o00, {5'd5, 5'd4}, '0, '0, 5'd4, 5'd5, 5'd0, 3'd0, 3'd0, 3'd0, 4'b1001, 4'b0000, 2'b00, 1'b0);

      doReset();
      @(negedge clk);
      e = expFromVec(zeroVec);
      e.chkBusy = 1'b1;
      sbQ.push_back(e);
      checkOutput("reset");
      compareVal("reset.stall_cnt", hif.stall_cnt, 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[i]);
         sbQ.push_back(expFromVec(vecs[i]));
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i));
      end

      runMd(1'b1, 10, -1, 1'b1, "div");
      runMd(1'b0, 5, 2, 1'b1, "mult");

      // Reset lands in the third busy cycle of a divide.
      doReset();
      @(posedge clk);
      #1;
      hif.md_use_d    = 1'b1;
      hif.md_start_e  = 1'b1;
      hif.md_is_div_e = 1'b1;
      @(posedge clk);
      #1 hif.md_start_e = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      e = expFromVec(zeroVec);
      e.chkBusy = 1'b1;
      sbQ.push_back(e);
      @(negedge clk);
      checkOutput("midReset");
      #1 reset = 1'b0;
      runMd(1'b0, 5, -1, 1'b0, "afterReset");

      doReset();
      @(posedge clk);
      #1 applyStimulus(vecs[2]);
      repeat (4) @(posedge clk);
      #1 applyStimulus(zeroVec);
      @(negedge clk);
`ifdef HAZARD_STALL_CNT_EN
      expCnt = 4;
`else
      expCnt = 0;
`endif
      compareVal("stall_cnt", hif.stall_cnt, 32'(expCnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage pipeline and successor to the two-source Tuse/Tnew hazard unit. It generates forwarding selects for NUM_SRC register sources at D, E and M, and the D-stage stall. Forwarding is gated on producer readiness (Tnew == 0). A registered multiply/divide busy tracker stalls MD-class instructions in D while the MDU is occupied.

## Interface
Parameters:
- NUM_SRC, 2, register read sources per instruction
- REG_AW, 5, register address width
- T_W, 3, Tuse/Tnew width
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports (source i occupies slice [i*W +: W] of every flattened bus). Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tuse_d  in  NUM_SRC*T_W  Tuse per D source
- rs_d / rs_e / rs_m  in  NUM_SRC*REG_AW  source addresses in D / E / M
- rd_e / rd_m / rd_w  in  REG_AW  destination address in E / M / W; 0 means no write
- tnew_e / tnew_m / tnew_w  in  T_W  producer Tnew in E / M / W
- md_start_e  in  1  MD start in E this cycle (one-cycle pulse)
- md_is_div_e  in  1  qualifies md_start_e: 1 = div, 0 = mult
- md_use_d  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- fwd_d  out  2*NUM_SRC  per source: 0 orig, 1 from E, 2 from M
- fwd_e  out  2*NUM_SRC  per source: 0 orig, 1 from M, 2 from W
- fwd_m  out  NUM_SRC  per source: 0 orig, 1 from W
- stall  out  1  freeze PC and F/D; bubble into E
- md_busy  out  1  MDU occupied (registered)
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- A producer matches source i when its rd is nonzero and equals rs_i. Priority is the younger stage: at D, E over M; at E, M over W.
- Forwarding is taken only when the matched producer's Tnew == 0. If the younger match is not ready, the older ready match is not used. The select is orig, and the stall logic covers the source.
- Register stall for D source i:
  - an E match with tuse_i < tnew_e, or
  - an M match with tuse_i < tnew_m.
- W never causes a stall.
- MD stall = md_use_d && (md_busy || md_start_e).
- stall = OR of all register stalls and the MD stall.
- Busy tracker: a down-counter cnt of width clog2(DIV_CYCLES+1).
  - On md_start_e while cnt == 0: load DIV_CYCLES if md_is_div_e, else MULT_CYCLES.
  - Otherwise, if cnt != 0: decrement by 1.
  - md_busy = (cnt != 0), registered.
- md_start_e while busy is illegal, because D was stalled. It is ignored and cnt continues to decrement.

## Timing
- fwd_* and stall are combinational, same cycle as their inputs. They have no reset value and follow inputs immediately.
- md_busy rises the cycle after md_start_e and stays high exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). The start cycle itself is covered by the md_start_e term of the MD stall.
- The instruction stalled in D issues in the cycle md_busy first reads 0.
- Reset mid-operation: cnt, md_busy and stall_cnt clear to 0 immediately.
- After reset with all rd_* = 0 and md_use_d = 0: stall = 0 and all fwd_* = 0.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt increments on every clk cycle with stall = 1 and saturates at 0xFFFF_FFFF. It resets to 0.
- Macro undefined: stall_cnt is tied to 0 and the counter register is not built.

## Structure
- Forward select codes (FWD_D_*, FWD_E_*, FWD_M_*) and MD latency defaults live in the shared macros/constants package used by the datapath muxes.
- One sub-module: md_busy_tracker (cnt, load/decrement, md_busy). The rest is a generate loop over NUM_SRC.

## Test plan
- rs_d[0] = 5, rd_e = 5, tnew_e = 0, tuse = 0 -> fwd_d[0] = 1, stall = 0. Then tnew_e = 1 -> fwd_d[0] = 0, stall = 1.
- rd_e = rd_m = 7 with both Tnew = 0, rs_e[1] = 7, rd_w = 7 -> fwd_e[1] = 1, since M takes priority over W. Then rd_m = 0 -> fwd_e[1] = 2.
- rd_m = 0, rs_d = 0 in every stage -> no forward, no stall.
- md_start_e with md_is_div_e = 1, then md_use_d held high -> md_busy high for exactly 10 cycles, stall high for 11 cycles. With md_is_div_e = 0 the figures are 5 and 6.
- Reset asserted at busy cycle 3 -> md_busy = 0 that cycle; next md_start_e reloads the counter normally.
- HAZARD_STALL_CNT_EN defined, 4 stall cycles -> stall_cnt = 4. Undefined -> stall_cnt = 0.
